// File: rtl/board_rst_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : board_rst_cond_pkg
//  Purpose  : Shared constants, state encoding and helper function for the
//             board reset conditioner (board_rst_cond and its interface).
//  Contents : ST_W        state register width (2)
//             EVT_CNT_W   reset event counter width (8)
//             rst_state_e ST_HOLD=0, ST_REL_WAIT=1, ST_RUN=2, ST_ILLEGAL=3
//             cnt_width() width of the debounce/hold counter
//  Revision : 1.0  initial release
// ============================================================================
package board_rst_cond_pkg;

    localparam int ST_W      = 2;
    localparam int EVT_CNT_W = 8;

    // Encoding 3 is never entered on purpose; it exists so the FSM can name
    // it and recover from it explicitly.
    typedef enum logic [ST_W-1:0] {
        ST_HOLD     = 2'd0,
        ST_REL_WAIT = 2'd1,
        ST_RUN      = 2'd2,
        ST_ILLEGAL  = 2'd3
    } rst_state_e;

    // The same counter times both the hold window and the debounce window,
    // so it must hold the larger terminal value without wrapping.
    function automatic int cnt_width(input int debounce_cyc, input int hold_cyc);
        int max_cyc;
        max_cyc = (debounce_cyc > hold_cyc) ? debounce_cyc : hold_cyc;
        return $clog2(max_cyc + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_rst_cond_if.sv
`default_nettype none
// ============================================================================
//  Module   : board_rst_cond_if
//  Purpose  : Groups the raw reset sources and conditioned reset/status
//             signals of board_rst_cond.
//  Signals  : BOARD_RST_SW  raw push-button (asynchronous)
//             SL_RST_N      raw FX3 reset, active-low (asynchronous)
//             SL_RST_N_OUT  conditioned reset, active-low
//             RST_EVT       one-cycle pulse per RUN->HOLD transition
//             RST_STATE     current FSM state
//             RST_EVT_CNT   reset event count
//  Modports : master  drives the raw sources, observes status (board / bench)
//             slave   the conditioner itself
//  Revision : 1.0  initial release
// ============================================================================
interface board_rst_cond_if;

    logic                                       BOARD_RST_SW;
    logic                                       SL_RST_N;
    logic                                       SL_RST_N_OUT;
    logic                                       RST_EVT;
    logic [board_rst_cond_pkg::ST_W-1:0]        RST_STATE;
    logic [board_rst_cond_pkg::EVT_CNT_W-1:0]   RST_EVT_CNT;

    modport master (
        output BOARD_RST_SW,
        output SL_RST_N,
        input  SL_RST_N_OUT,
        input  RST_EVT,
        input  RST_STATE,
        input  RST_EVT_CNT
    );

    modport slave (
        input  BOARD_RST_SW,
        input  SL_RST_N,
        output SL_RST_N_OUT,
        output RST_EVT,
        output RST_STATE,
        output RST_EVT_CNT
    );

endinterface
`default_nettype wire

// File: rtl/board_rst_cond_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : board_rst_cond_sync2
//  Purpose  : Two-flop synchroniser for one asynchronous level.
//  Params   : RST_VAL  value both flops take while rst_n is low
//  Ports    : clk    in  sampling clock
//             rst_n  in  synchronous active-low reset
//             d      in  asynchronous input level
//             q      out synchronised level, 2 cycles latency
//  Revision : 1.0  initial release
// ============================================================================
module board_rst_cond_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/board_rst_cond.sv
`default_nettype none
// ============================================================================
//  Module   : board_rst_cond
//  Purpose  : Conditions the raw board reset sources (push-button and the
//             FX3 SL_RST_N) into one clean, registered active-low reset with
//             2-flop synchronisation, symmetric debounce, a minimum hold
//             window and an event pulse for status logging.
//  Params   : DEBOUNCE_CYC  cycles a request level must hold to be accepted
//             HOLD_CYC      minimum cycles SL_RST_N_OUT stays low
//             SW_ACT_HIGH   1: BOARD_RST_SW active-high, 0: active-low
//  Ports    : SYS_CLK    in  sole clock
//             SYS_RST_N  in  synchronous active-low reset
//             bus        board_rst_cond_if.slave
//                        BOARD_RST_SW, SL_RST_N in;
//                        SL_RST_N_OUT, RST_EVT, RST_STATE, RST_EVT_CNT out
//  Config   : BOARD_RST_COND_CNT_EN  defined: saturating RST_EVT_CNT built;
//                                    undefined: RST_EVT_CNT tied to zero
//  Revision : 1.0  initial release
// ============================================================================
module board_rst_cond
    import board_rst_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 80_000,
    parameter int HOLD_CYC     = 16,
    parameter int SW_ACT_HIGH  = 1
) (
    input  logic               SYS_CLK,
    input  logic               SYS_RST_N,
    board_rst_cond_if.slave    bus
);

    localparam int                 c_cnt_w     = cnt_width(DEBOUNCE_CYC, HOLD_CYC);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEBOUNCE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    // ------------------------------------------------------------------
    // Input synchronisation. The push-button is normalised to an
    // "active" flag before synchronising so its idle value is always 0,
    // independent of the pin polarity.
    // ------------------------------------------------------------------
    logic sw_act_raw;
    logic sw_act_s;
    logic sl_rst_n_s;
    logic req_s;

    assign sw_act_raw = (SW_ACT_HIGH != 0) ? bus.BOARD_RST_SW : ~bus.BOARD_RST_SW;

    board_rst_cond_sync2 #(
        .RST_VAL (1'b0)
    ) u_sync2_sw (
        .clk   (SYS_CLK),
        .rst_n (SYS_RST_N),
        .d     (sw_act_raw),
        .q     (sw_act_s)
    );

    board_rst_cond_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync2_sl (
        .clk   (SYS_CLK),
        .rst_n (SYS_RST_N),
        .d     (bus.SL_RST_N),
        .q     (sl_rst_n_s)
    );

    // Both sources merge into a single request, so simultaneous assertion
    // produces one debounce run and one event.
    assign req_s = sw_act_s | ~sl_rst_n_s;

    // ------------------------------------------------------------------
    // FSM with shared hold/debounce counter
    // ------------------------------------------------------------------
    rst_state_e         state_q;
    rst_state_e         state_d;
    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;
    logic               out_q;
    logic               out_d;
    logic               evt_q;
    logic               evt_d;

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            evt_q   <= evt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;

        case (state_q)
            // Minimum low time after any assertion; requests are ignored.
            ST_HOLD: begin
                if (cnt_q == c_hold_last) begin
                    state_d = ST_REL_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            // Release only after the request has been idle for a full
            // debounce window; any request activity restarts the window.
            ST_REL_WAIT: begin
                if (req_s) begin
                    cnt_d = '0;
                end else if (cnt_q == c_deb_last) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            // Assert only after the request has been steady for a full
            // debounce window; shorter glitches just clear the counter.
            ST_RUN: begin
                if (!req_s) begin
                    cnt_d = '0;
                end else if (cnt_q == c_deb_last) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    evt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase

        // Output is registered from the next state so it changes on the
        // same edge as the state transition.
        out_d = (state_d == ST_RUN);
    end

    assign bus.SL_RST_N_OUT = out_q;
    assign bus.RST_EVT      = evt_q;
    assign bus.RST_STATE    = state_q;

    // ------------------------------------------------------------------
    // Optional reset event counter
    // ------------------------------------------------------------------
`ifdef BOARD_RST_COND_CNT_EN
    logic [EVT_CNT_W-1:0] evt_cnt_q;
    logic [EVT_CNT_W-1:0] evt_cnt_d;

    // Counts on the edge that raises RST_EVT so the count and the pulse
    // become visible together; saturates instead of wrapping.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (evt_d && (evt_cnt_q != {EVT_CNT_W{1'b1}})) begin
            evt_cnt_d = evt_cnt_q + EVT_CNT_W'(1);
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign bus.RST_EVT_CNT = evt_cnt_q;
`else
    assign bus.RST_EVT_CNT = '0;
`endif

endmodule
`default_nettype wire
